bus_width_decrease: RTL and testbench
=====================================

Name: bus_width_decrease

Overview:
- Serializer: accepts one wide word per valid/ready handshake and emits it as SIZE_IN/SIZE_OUT consecutive narrow beats over a valid/ready output bus.
- Sits directly upstream of the narrow-to-wide bus width increaser, so wide data can cross a narrow link and be reassembled on the far side.
- Both blocks share the same LITTLE_ENDIAN meaning: the LSB slice travels first.
- The input side is back-pressured while a word is being serialized. A new word is accepted in the same cycle as the last beat, so streaming has no bubble.

Parameters:
- SIZE_IN, 32, width of the wide input bus. Must be an integer multiple of SIZE_OUT.
- SIZE_OUT, 8, width of the narrow output bus.
- LITTLE_ENDIAN, 1, beat order. 1 = bits [SIZE_OUT-1:0] go out first. 0 = the MS slice goes out first.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a wide word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  SIZE_IN  wide word. Sampled on the in_valid && in_ready edge.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_data  output  SIZE_OUT  current narrow beat.
- out_last  output  1  current beat is the final beat of its word.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Derived constants: BEATS = SIZE_IN/SIZE_OUT. Beat counter width is max(1, $clog2(BEATS)).
- Elaboration check: error if SIZE_IN % SIZE_OUT != 0 or SIZE_OUT > SIZE_IN.
- State: word register word_q[SIZE_IN], beat counter cnt (beats already sent), and FSM {EMPTY, BUSY}.
- Reset, while rst_n is low: FSM = EMPTY, cnt = 0, word_q = 0. Outputs are out_valid = 0, out_last = 0, out_data = 0 and in_ready = 0. in_ready is forced low during reset.
- After reset releases: in_ready = 1, since the FSM is EMPTY.
- in_ready is combinational: (FSM == EMPTY) || (out_valid && out_ready && out_last).
- out_valid = (FSM == BUSY).
- out_last = BUSY && (cnt == BEATS-1).
- out_data when LITTLE_ENDIAN = 1: word_q[cnt*SIZE_OUT +: SIZE_OUT].
- out_data when LITTLE_ENDIAN = 0: word_q[(BEATS-1-cnt)*SIZE_OUT +: SIZE_OUT].
- out_data is driven straight from registers, with no combinational path from in_data.
- EMPTY state, in_valid high: on the edge, word_q <= in_data, cnt <= 0, FSM -> BUSY. The first beat is valid the next cycle, so latency is 1 cycle.
- BUSY state, out_valid && out_ready && !out_last: cnt <= cnt+1.
- BUSY state, final beat accepted with in_valid high: load the new word, cnt <= 0, stay BUSY. This gives a zero-bubble stream.
- BUSY state, final beat accepted with in_valid low: FSM -> EMPTY, cnt <= 0. word_q keeps its value but is don't-care.
- Stall: while out_valid && !out_ready, out_data, out_last and cnt hold stable. in_ready stays low except as allowed by the in_ready rule above.
- Throughput: one beat per cycle. Sustained rate is one wide word per BEATS cycles.
- BEATS == 1: the block degenerates to a one-entry pipeline register. out_last is always 1 while valid.
- Reset mid-word: the partial word is discarded. No beats are emitted after rst_n deasserts until a new word is accepted.
- in_valid when in_ready is low: ignored. in_data is not sampled.

Decomposition:
- Shared package bus_width_pkg holds:
  - the endianness constant names (BEAT_LSB_FIRST = 1, BEAT_MSB_FIRST = 0);
  - function beats(in, out) returning the ratio;
  - function cnt_width(n) returning max(1, $clog2(n)).
- The bus width increaser uses the same package so that endianness cannot diverge between the two blocks.
- No sub-module. The FSM, counter and slice mux stay in one module.

Test Plan:
- Single word, default parameters: in_data = 32'hDDCCBBAA, out_ready = 1 → beats AA, BB, CC, DD on cycles 1-4. out_last high on DD only. in_ready = 1 again in cycle 4.
- LITTLE_ENDIAN = 0, same word → beats DD, CC, BB, AA in that order. out_last on AA.
- Back-to-back: in_valid held high with 32'h03020100 then 32'h07060504 → 8 consecutive beats 00..07 with no gap. The second word is accepted on the cycle beat 03 is accepted.
- Backpressure: out_ready low for 3 cycles at beat 2 → out_data holds 8'h02 stable. cnt is unchanged and in_ready = 0. The stream resumes with 02, 03.
- Reset mid-word: assert rst_n low after beat 1 of 32'hDDCCBBAA → out_valid drops to 0 immediately (asynchronously). After release no CC/DD beats appear, and the next word starts at its LSB.
- BEATS = 1 (SIZE_IN = SIZE_OUT = 8): words 8'h5A, 8'hA5 streamed → 1-cycle latency, one word per cycle, out_last constantly 1 while valid.
- End-to-end: connect this block to the bus width increaser with matching parameters and send random words → every reassembled wide word equals the word that was sent.

Source files
------------

// File: rtl/bus_width_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_width_pkg
//  Purpose  : Definitions shared by the bus width decreaser (serializer) and
//             increaser (deserializer). Both blocks take beat order and
//             width ratios from here, so the two ends of a narrow link
//             cannot disagree about slice order.
//  Contents : BEAT_LSB_FIRST / BEAT_MSB_FIRST - beat order constants
//             beats(size_in, size_out)      - narrow beats per wide word
//             cnt_width(n)                  - beat counter width, min 1
//  Revision : 1.0 - initial release
// ============================================================================
package bus_width_pkg;

  // Beat order. LSB-first means bits [SIZE_OUT-1:0] travel first.
  localparam int BEAT_LSB_FIRST = 1;
  localparam int BEAT_MSB_FIRST = 0;

  // Number of narrow beats that make up one wide word.
  function automatic int beats(input int size_in, input int size_out);
    return size_in / size_out;
  endfunction

  // Counter width for n beats. At least one bit, so that a 1:1 ratio
  // still produces a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : bus_width_pkg
`default_nettype wire

// File: rtl/bus_width_decrease.sv
`default_nettype none
// ============================================================================
//  Module   : bus_width_decrease
//  Purpose  : Wide-to-narrow serializer. Accepts one SIZE_IN word per
//             valid/ready handshake and emits it as SIZE_IN/SIZE_OUT narrow
//             beats. A new word is loaded on the same cycle the last beat is
//             accepted, so a continuous stream has no idle cycle.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             in_valid   - wide word present on in_data
//             in_ready   - block accepts a word this cycle
//             in_data    - wide word [SIZE_IN-1:0]
//             out_valid  - out_data holds a beat
//             out_ready  - downstream accepts the beat this cycle
//             out_data   - narrow beat [SIZE_OUT-1:0]
//             out_last   - final beat of the current word
//  Revision : 1.0 - initial release
// ============================================================================
module bus_width_decrease
  import bus_width_pkg::*;
#(
  parameter int SIZE_IN       = 32,
  parameter int SIZE_OUT      = 8,
  parameter int LITTLE_ENDIAN = BEAT_LSB_FIRST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE_IN-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE_OUT-1:0] out_data,
  output logic                out_last
);

  localparam int BEATS = beats(SIZE_IN, SIZE_OUT);
  localparam int CW    = cnt_width(BEATS);

  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;

  // Reject ratios that cannot be split into whole beats.
  generate
    if (((SIZE_IN % SIZE_OUT) != 0) || (SIZE_OUT > SIZE_IN)) begin : g_bad_size
      $error("bus_width_decrease: SIZE_IN must be a whole multiple of SIZE_OUT");
    end
  endgenerate

  logic [0:0]         state;
  logic [CW-1:0]      cnt;       // beats of word_q already sent
  logic [SIZE_IN-1:0] word_q;
  logic [CW-1:0]      slice_sel;
  logic               beat_done;

  assign out_valid = (state == BUSY);
  assign out_last  = (state == BUSY) && (cnt == LAST_CNT);
  assign beat_done = out_valid && out_ready;

  // Ready while empty, or when the final beat leaves this cycle so that the
  // next word can take its place without a bubble. Held low during reset.
  assign in_ready = rst_n && ((state == EMPTY) || (beat_done && out_last));

  // Output slice is taken from registers only; in_data never reaches
  // out_data combinationally.
  always_comb begin
    if (LITTLE_ENDIAN != BEAT_MSB_FIRST) begin
      slice_sel = cnt;
    end else begin
      slice_sel = LAST_CNT - cnt;
    end
    out_data = word_q[int'(slice_sel)*SIZE_OUT +: SIZE_OUT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      cnt    <= '0;
      word_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            word_q <= in_data;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (beat_done) begin
            if (out_last) begin
              cnt <= '0;
              if (in_valid) begin
                word_q <= in_data;      // back-to-back word, stay BUSY
              end else begin
                state <= EMPTY;         // word_q left stale on purpose
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= EMPTY;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : bus_width_decrease
`default_nettype wire

// File: tb/tb_bus_width_decrease.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_width_decrease
//  Purpose  : Self-checking bench for bus_width_decrease. Three instances
//             share one stimulus: 32->8 LSB-first, 32->8 MSB-first and
//             8->8 (single beat). Each instance is tracked by a queue of the
//             beats it still owes; outputs are compared against that queue
//             every cycle, with literal checks pinning the directed cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_width_decrease;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_data;
  logic       b_in_ready, b_out_valid, b_out_last;
  logic [7:0] b_out_data;
  logic       c_in_ready, c_out_valid, c_out_last;
  logic [7:0] c_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];

  always #5 clk = ~clk;

  bus_width_decrease #(.SIZE_IN(32), .SIZE_OUT(8), .LITTLE_ENDIAN(1)) u_le (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last)
  );

  bus_width_decrease #(.SIZE_IN(32), .SIZE_OUT(8), .LITTLE_ENDIAN(0)) u_be (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_last(b_out_last)
  );

  bus_width_decrease #(.SIZE_IN(8), .SIZE_OUT(8), .LITTLE_ENDIAN(1)) u_one (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data[7:0]),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_last(c_out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one instance against its pending-beat queue (size + head).
  task automatic check_inst(input string nm, input int sz, input beat_t head,
                            input logic rdy, input logic vld,
                            input logic [7:0] dat, input logic lst);
    logic exp_rdy;
    exp_rdy = rst_n && ((sz == 0) || (sz == 1 && out_ready));
    check({nm, ".in_ready"},  {31'd0, rdy}, {31'd0, exp_rdy});
    check({nm, ".out_valid"}, {31'd0, vld}, {31'd0, (sz > 0)});
    if (sz > 0) begin
      check({nm, ".out_data"}, {24'd0, dat}, {24'd0, head.data});
      check({nm, ".out_last"}, {31'd0, lst}, {31'd0, head.last});
    end
  endtask

  task automatic check_all();
    beat_t ha, hb, hc;
    ha = (qa.size() > 0) ? qa[0] : '0;
    hb = (qb.size() > 0) ? qb[0] : '0;
    hc = (qc.size() > 0) ? qc[0] : '0;
    check_inst("le",  qa.size(), ha, a_in_ready, a_out_valid, a_out_data, a_out_last);
    check_inst("be",  qb.size(), hb, b_in_ready, b_out_valid, b_out_data, b_out_last);
    check_inst("one", qc.size(), hc, c_in_ready, c_out_valid, c_out_data, c_out_last);
  endtask

  // Advance the model by the handshakes the coming rising edge will see.
  task automatic update_model();
    bit ra, rb, rc;
    ra = (qa.size() == 0) || (qa.size() == 1 && out_ready);
    rb = (qb.size() == 0) || (qb.size() == 1 && out_ready);
    rc = (qc.size() == 0) || (qc.size() == 1 && out_ready);
    if (qa.size() > 0 && out_ready) void'(qa.pop_front());
    if (qb.size() > 0 && out_ready) void'(qb.pop_front());
    if (qc.size() > 0 && out_ready) void'(qc.pop_front());
    if (in_valid && ra) for (int i = 0; i < 4; i++) qa.push_back({in_data[8*i +: 8], i == 3});
    if (in_valid && rb) for (int i = 3; i >= 0; i--) qb.push_back({in_data[8*i +: 8], i == 0});
    if (in_valid && rc) qc.push_back({in_data[7:0], 1'b1});
  endtask

  // Drive inputs at the falling edge, check 1 ns later, then step the model.
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    check_all();
    update_model();
  endtask

  logic [7:0] exp_le[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] exp_be[4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

  initial begin
    // Reset state
    #1;
    check("rst.in_ready",  {31'd0, a_in_ready},  32'd0);
    check("rst.out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst.out_last",  {31'd0, a_out_last},  32'd0);
    check("rst.out_data",  {24'd0, a_out_data},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst.in_ready", {31'd0, a_in_ready}, 32'd1);

    // Single word, both beat orders
    step(1'b1, 32'hDDCCBBAA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check("single.le_data", {24'd0, a_out_data}, {24'd0, exp_le[i]});
      check("single.be_data", {24'd0, b_out_data}, {24'd0, exp_be[i]});
      check("single.last",    {31'd0, a_out_last}, {31'd0, (i == 3)});
    end
    check("single.ready_on_last", {31'd0, a_in_ready}, 32'd1);

    // Back-to-back: second word held until beat 03 is accepted
    step(1'b1, 32'h03020100, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(i < 4, 32'h07060504, 1'b1);
      check("b2b.data",  {24'd0, a_out_data},  i);
      check("b2b.valid", {31'd0, a_out_valid}, 32'd1);
    end
    step(1'b0, 32'h0, 1'b1);

    // Backpressure at beat 2
    step(1'b1, 32'h03020100, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hFFFFFFFF, 1'b0);
      check("stall.data",  {24'd0, a_out_data}, 32'h02);
      check("stall.ready", {31'd0, a_in_ready}, 32'd0);
    end
    step(1'b0, 32'h0, 1'b1);
    check("resume.data02", {24'd0, a_out_data}, 32'h02);
    step(1'b0, 32'h0, 1'b1);
    check("resume.data03", {24'd0, a_out_data}, 32'h03);
    step(1'b0, 32'h0, 1'b1);

    // Reset after beat AA of a word
    step(1'b1, 32'hDDCCBBAA, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("midrst.beatAA", {24'd0, a_out_data}, 32'hAA);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.valid_drop", {31'd0, a_out_valid}, 32'd0);
    check("midrst.ready_low",  {31'd0, a_in_ready},  32'd0);
    qa.delete(); qb.delete(); qc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h44332211, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("midrst.new_lsb", {24'd0, a_out_data}, 32'h11);

    // Single-beat instance: one word per cycle, last always set
    step(1'b1, 32'h5A, 1'b1);
    step(1'b1, 32'hA5, 1'b1);
    check("one.data5A", {24'd0, c_out_data}, 32'h5A);
    check("one.last",   {31'd0, c_out_last}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    check("one.dataA5", {24'd0, c_out_data}, 32'hA5);

    // Randomized traffic with stalls and gaps
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_width_decrease
`default_nettype wire
